// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped I/O bank linking the CPU I/O bus to NUM_PORTS devices.
// Ports: clk/reset (sync, active-high); cpu_en/we/addr/wdata -> cpu_rdata/cpu_rvalid;
//        dev_in_data/dev_in_valid capture; dev_out_data/dev_out_strobe drive; irq.
// Latency: writes land at the sampling edge; read data appears one edge after sampling.
//          There is no backpressure, and the bank accepts one access every cycle.
module io_port_bank #(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_en,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_rvalid,
  input  logic [NUM_PORTS*DATA_W-1:0]   dev_in_data,
  input  logic [NUM_PORTS-1:0]          dev_in_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   dev_out_data,
  output logic [NUM_PORTS-1:0]          dev_out_strobe,
  output logic                          irq
);

  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(NUM_PORTS);
  localparam logic [ADDR_W-1:0] A_OVF     = ADDR_W'(NUM_PORTS + 1);
  localparam logic [ADDR_W-1:0] A_IRQMASK = ADDR_W'(NUM_PORTS + 2);

  logic [NUM_PORTS*DATA_W-1:0] out_q, out_d;
  logic [NUM_PORTS*DATA_W-1:0] in_q, in_d;
  logic [NUM_PORTS-1:0]        pend_q, pend_d;
  logic [NUM_PORTS-1:0]        ovf_q, ovf_d;
  logic [NUM_PORTS-1:0]        mask_q, mask_d;
  logic [NUM_PORTS-1:0]        strobe_q, strobe_d;
  logic [DATA_W-1:0]           rd_pipe_q, rd_pipe_d;
  logic                        rd_pipe_vld_q, rd_pipe_vld_d;
  logic [DATA_W-1:0]           rdata_q, rdata_d;
  logic                        rvalid_q, rvalid_d;
  logic                        irq_q, irq_d;
  logic                        rd_en, wr_en;
  logic [NUM_PORTS-1:0]        rd_clr;

  always_comb begin
    rd_en         = cpu_en & ~cpu_we;
    wr_en         = cpu_en & cpu_we;
    out_d         = out_q;
    in_d          = in_q;
    pend_d        = pend_q;
    ovf_d         = ovf_q;
    mask_d        = mask_q;
    strobe_d      = '0;
    rd_clr        = '0;
    // Read data is sampled from the pre-edge state, so a same-cycle capture
    // or overflow event never leaks into the response.
    rd_pipe_d     = '0;
    rd_pipe_vld_d = rd_en;
    rdata_d       = rd_pipe_vld_q ? rd_pipe_q : rdata_q;
    rvalid_d      = rd_pipe_vld_q;
    irq_d         = |(pend_q & mask_q);

    for (int p = 0; p < NUM_PORTS; p++) begin
      if (cpu_addr == ADDR_W'(p)) begin
        if (rd_en) begin
          rd_pipe_d = in_q[p*DATA_W +: DATA_W];
          rd_clr[p] = 1'b1;
        end
        if (wr_en) begin
          out_d[p*DATA_W +: DATA_W] = cpu_wdata;
          strobe_d[p]               = 1'b1;
        end
      end
    end

    if (rd_en && cpu_addr == A_STATUS)  rd_pipe_d = DATA_W'(pend_q);
    if (rd_en && cpu_addr == A_OVF) begin
      rd_pipe_d = DATA_W'(ovf_q);
      ovf_d     = '0;
    end
    if (rd_en && cpu_addr == A_IRQMASK) rd_pipe_d = DATA_W'(mask_q);
    if (wr_en && cpu_addr == A_IRQMASK) mask_d    = cpu_wdata[NUM_PORTS-1:0];

    // Capture runs after the read-to-clear above so a new overflow wins, and
    // a capture racing a DATA read keeps pending set without flagging overflow.
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (dev_in_valid[p]) begin
        in_d[p*DATA_W +: DATA_W] = dev_in_data[p*DATA_W +: DATA_W];
        pend_d[p]                = 1'b1;
        if (pend_q[p] && !rd_clr[p]) ovf_d[p] = 1'b1;
      end else if (rd_clr[p]) begin
        pend_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q         <= '0;
      in_q          <= '0;
      pend_q        <= '0;
      ovf_q         <= '0;
      mask_q        <= '0;
      strobe_q      <= '0;
      rd_pipe_q     <= '0;
      rd_pipe_vld_q <= 1'b0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      out_q         <= out_d;
      in_q          <= in_d;
      pend_q        <= pend_d;
      ovf_q         <= ovf_d;
      mask_q        <= mask_d;
      strobe_q      <= strobe_d;
      rd_pipe_q     <= rd_pipe_d;
      rd_pipe_vld_q <= rd_pipe_vld_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
      irq_q         <= irq_d;
    end
  end

  assign cpu_rdata      = rdata_q;
  assign cpu_rvalid     = rvalid_q;
  assign dev_out_data   = out_q;
  assign dev_out_strobe = strobe_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed bench for io_port_bank with a cycle-level reference model.
// Ports: drives every DUT input and compares every DUT output on each falling edge.
// Includes hand-computed literal checks for the main scenarios.
module tb_io_port_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en, cpu_we;
  logic [6:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic [63:0] dev_in_data;
  logic [7:0]  dev_in_valid;
  logic [63:0] dev_out_data;
  logic [7:0]  dev_out_strobe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  io_port_bank #(.NUM_PORTS(8), .DATA_W(8), .ADDR_W(7)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid),
    .dev_out_data(dev_out_data), .dev_out_strobe(dev_out_strobe), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: port state as plain arrays; reads become queued responses
  // that surface one edge after the edge that sampled them.
  typedef struct { int due; int val; } resp_t;
  resp_t  rq[$];
  int     out_m[8], in_m[8];
  bit     pend_m[8], ovf_m[8];
  int     mask_m;
  int     cyc = 0;
  bit     started = 1'b0;
  logic [7:0] exp_rdata;
  logic       exp_rvalid, exp_irq;
  logic [7:0] exp_strobe;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  a, rv;
    bit  rd, any;
    cyc++;
    started = 1'b1;
    exp_strobe = '0;
    exp_rvalid = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rdata  = rq[0].val[7:0];
      exp_rvalid = 1'b1;
      void'(rq.pop_front());
    end
    if (reset) begin
      for (int p = 0; p < 8; p++) begin
        out_m[p] = 0; in_m[p] = 0; pend_m[p] = 0; ovf_m[p] = 0;
      end
      mask_m = 0;
      rq.delete();
      exp_rdata = '0; exp_rvalid = 1'b0; exp_irq = 1'b0;
    end else begin
      any = 1'b0;
      for (int p = 0; p < 8; p++) if (pend_m[p] && mask_m[p]) any = 1'b1;
      exp_irq = any;
      a  = int'(cpu_addr);
      rd = cpu_en && !cpu_we;
      if (rd) begin
        rv = 0;
        if (a < 8) rv = in_m[a];
        else if (a == 8)  for (int p = 0; p < 8; p++) rv += int'(pend_m[p]) << p;
        else if (a == 9) begin
          for (int p = 0; p < 8; p++) rv += int'(ovf_m[p]) << p;
          for (int p = 0; p < 8; p++) ovf_m[p] = 0;
        end
        else if (a == 10) rv = mask_m;
        rq.push_back('{cyc + 1, rv});
      end
      if (cpu_en && cpu_we) begin
        if (a < 8) begin out_m[a] = int'(cpu_wdata); exp_strobe[a] = 1'b1; end
        if (a == 10) mask_m = int'(cpu_wdata);
      end
      for (int p = 0; p < 8; p++) begin
        if (dev_in_valid[p]) begin
          if (pend_m[p] && !(rd && a == p)) ovf_m[p] = 1;
          in_m[p]   = int'(dev_in_data[p*8 +: 8]);
          pend_m[p] = 1;
        end else if (rd && a == p) begin
          pend_m[p] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] packed_out;
    if (started) begin
      for (int p = 0; p < 8; p++) packed_out[p*8 +: 8] = out_m[p][7:0];
      chk("model_out_data", dev_out_data, packed_out);
      chk("model_strobe", {56'd0, dev_out_strobe}, {56'd0, exp_strobe});
      chk("model_irq", {63'd0, irq}, {63'd0, exp_irq});
      chk("model_rvalid", {63'd0, cpu_rvalid}, {63'd0, exp_rvalid});
      chk("model_rdata", {56'd0, cpu_rdata}, {56'd0, exp_rdata});
    end
  end

  // One step = one set of inputs sampled at the next rising edge.
  task automatic step(input bit en, input bit we, input int a, input logic [7:0] wd,
                      input logic [7:0] vld, input logic [7:0] vdat);
    @(posedge clk); #2;
    cpu_en = en; cpu_we = we; cpu_addr = 7'(a); cpu_wdata = wd;
    dev_in_valid = vld;
    for (int p = 0; p < 8; p++) if (vld[p]) dev_in_data[p*8 +: 8] = vdat;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic rd(input string name, input int a, input logic [7:0] exp);
    step(1'b1, 1'b0, a, 8'h00, 8'h00, 8'h00);
    idle();
    idle();
    @(negedge clk);
    chk({name, "_rvalid"}, {63'd0, cpu_rvalid}, 64'd1);
    chk(name, {56'd0, cpu_rdata}, {56'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd0; cpu_wdata = 8'h00;
    dev_in_data = '0; dev_in_valid = '0;
    @(posedge clk); #2;
    cpu_we = 1'b1; cpu_addr = 7'd3; cpu_wdata = 8'hFF;
    @(posedge clk); #2;
    reset = 1'b0; cpu_en = 1'b0; cpu_we = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_out_data", dev_out_data, 64'd0);
    chk("rst_rvalid", {63'd0, cpu_rvalid}, 64'd0);
    chk("rst_rdata", {56'd0, cpu_rdata}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_strobe", {56'd0, dev_out_strobe}, 64'd0);

    // Write port 3
    step(1'b1, 1'b1, 3, 8'hA5, 8'h00, 8'h00);
    idle();
    @(negedge clk);
    chk("wr_out_data", dev_out_data, 64'h0000_0000_A500_0000);
    chk("wr_strobe", {56'd0, dev_out_strobe}, 64'h08);
    idle();
    @(negedge clk);
    chk("wr_strobe_off", {56'd0, dev_out_strobe}, 64'h00);

    // Capture and read
    step(1'b0, 1'b0, 0, 8'h00, 8'h02, 8'h3C);
    idle();
    rd("cap_status", 8, 8'h02);
    rd("cap_data1", 1, 8'h3C);
    rd("cap_status_clr", 8, 8'h00);

    // Overflow
    step(1'b0, 1'b0, 0, 8'h00, 8'h01, 8'h11);
    step(1'b0, 1'b0, 0, 8'h00, 8'h01, 8'h22);
    idle();
    rd("ovf_data0", 0, 8'h22);
    rd("ovf_read1", 9, 8'h01);
    rd("ovf_read2", 9, 8'h00);

    // Same-cycle read and capture on port 2
    step(1'b0, 1'b0, 0, 8'h00, 8'h04, 8'h55);
    idle();
    step(1'b1, 1'b0, 2, 8'h00, 8'h04, 8'h66);
    idle();
    idle();
    @(negedge clk);
    chk("race_rdata", {56'd0, cpu_rdata}, 64'h55);
    rd("race_status", 8, 8'h04);
    rd("race_data2", 2, 8'h66);
    rd("race_ovf", 9, 8'h00);

    // IRQ
    step(1'b1, 1'b1, 10, 8'h04, 8'h00, 8'h00);
    idle();
    rd("irq_mask", 10, 8'h04);
    step(1'b0, 1'b0, 0, 8'h00, 8'h04, 8'h77);
    idle();
    @(negedge clk);
    chk("irq_not_yet", {63'd0, irq}, 64'd0);
    idle();
    @(negedge clk);
    chk("irq_rise", {63'd0, irq}, 64'd1);
    rd("irq_data2", 2, 8'h77);
    chk("irq_fall", {63'd0, irq}, 64'd0);
    step(1'b0, 1'b0, 0, 8'h00, 8'h01, 8'h99);
    idle();
    idle();
    @(negedge clk);
    chk("irq_masked", {63'd0, irq}, 64'd0);
    rd("oor_read20", 20, 8'h00);
    rd("oor_read127", 127, 8'h00);

    // STATUS write ignored
    step(1'b1, 1'b1, 8, 8'hFF, 8'h00, 8'h00);
    idle();
    rd("status_wr_ign", 8, 8'h01);

    // OVF read racing a new overflow on port 0: pre-event value, set wins
    step(1'b1, 1'b0, 9, 8'h00, 8'h01, 8'hAA);
    idle();
    idle();
    @(negedge clk);
    chk("ovf_race_rdata", {56'd0, cpu_rdata}, 64'h00);
    rd("ovf_race_after", 9, 8'h01);

    // Back-to-back reads, checked by the model every cycle
    step(1'b1, 1'b0, 0, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b0, 3, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b0, 10, 8'h00, 8'h00, 8'h00);
    idle();
    idle();
    idle();
    @(negedge clk);
    chk("b2b_last", {56'd0, cpu_rdata}, 64'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
